// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: default geometry, packed row type and level-width helper.
package sa_pkg;

  localparam int N_DEF     = 4;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;
  localparam int RW_DEF    = 8;

  typedef logic signed [DW_DEF-1:0] sum_t;
  typedef sum_t [N_DEF-1:0]         row_t;

  // Occupancy must represent 0..DEPTH inclusive, hence the extra bit.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LVL_W_DEF = lvl_width(DEPTH_DEF);

endpackage

// File: rtl/sa_result_drain_if.sv
// Aligned-row output stream of the result drain: valid/ready handshake toward writeback.
interface sa_result_drain_if
  import sa_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
);
  logic [N*DW-1:0] out_data;
  logic [RW-1:0]   out_row;
  logic            out_valid;
  logic            out_ready;

  modport master (output out_data, output out_row, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_row, input  out_valid, output out_ready);
endinterface

// File: rtl/sa_row_fifo.sv
// Synchronous row FIFO; a push while full is accepted only when a pop frees a slot the same cycle.
module sa_row_fifo
  import sa_pkg::*;
#(
  parameter  int W     = N_DEF * DW_DEF + RW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int LW    = lvl_width(DEPTH),
  localparam int AW    = LW - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [LW-1:0] wr_q, rd_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == LW'(DEPTH));
  assign empty_o = (level_o == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers define validity and the read port is gated.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/sa_result_drain.sv
// Bottom-edge reader of the systolic array: de-skews columns, buffers rows, flags faults.
// Optional build macro SA_DRAIN_RELU_EN clamps negative columns to 0 before the FIFO write.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int RW    = RW_DEF,
  localparam int LW    = lvl_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*DW-1:0]      col_sum,
  input  logic [N-1:0]         col_valid,
  input  logic                 clear,
  sa_result_drain_if.master    out_if,
  output logic                 skew_err,
  output logic                 overflow,
  output logic [LW-1:0]        level
);

  logic [N-1:0]          tail_v;
  logic [N-1:0][DW-1:0]  tail_d;
  logic [N*DW-1:0]       push_data;
  logic [N*DW+RW-1:0]    fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic                  all_v, any_v, push, pop, accepted;
  logic [RW-1:0]         row_q;
  logic                  skew_q, ovf_q;

  // Column j travels through N-j stages so every column reaches its tail on the same edge.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - j;
    logic              v_q [D];
    logic [DW-1:0]     d_q [D];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < D; s++) begin
          v_q[s] <= 1'b0;
          d_q[s] <= '0;
        end
      end else if (clear) begin
        for (int s = 0; s < D; s++) begin
          v_q[s] <= 1'b0;
          d_q[s] <= '0;
        end
      end else begin
        v_q[0] <= col_valid[j];
        if (col_valid[j]) d_q[0] <= col_sum[j*DW +: DW];
        for (int s = 1; s < D; s++) begin
          v_q[s] <= v_q[s-1];
          if (v_q[s-1]) d_q[s] <= d_q[s-1];
        end
      end
    end

    assign tail_v[j] = v_q[D-1];
    assign tail_d[j] = d_q[D-1];
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    push_data = tail_d;
`ifdef SA_DRAIN_RELU_EN
    for (int j = 0; j < N; j++) begin
      if (tail_d[j][DW-1]) push_data[j*DW +: DW] = '0;
    end
`endif
  end

  assign all_v    = &tail_v;
  assign any_v    = |tail_v;
  assign pop      = out_if.out_valid && out_if.out_ready && !clear;
  assign push     = all_v && !clear;
  assign accepted = push && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      skew_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      row_q  <= '0;
      skew_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accepted)          row_q  <= row_q + 1'b1;
      if (any_v && !all_v)   skew_q <= 1'b1;
      if (push && !accepted) ovf_q  <= 1'b1;
    end
  end

  sa_row_fifo #(
    .W     (N*DW + RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({row_q, push_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_if.out_data  = fifo_rdata[N*DW-1:0];
  assign out_if.out_row   = fifo_rdata[N*DW +: RW];
  assign out_if.out_valid = !fifo_empty;
  assign skew_err         = skew_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain with a sample-history/queue reference model checked every cycle.
module tb_sa_result_drain;
  import sa_pkg::*;

  localparam int N = 4, DW = 32, DEPTH = 4, RW = 8, LW = 3, W = N * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  col_sum;
  logic [N-1:0]  col_valid;
  logic          clear;
  logic          skew_err, overflow;
  logic [LW-1:0] level;

  sa_result_drain_if #(.N(N), .DW(DW), .RW(RW)) out_if ();

  sa_result_drain #(.N(N), .DW(DW), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_sum   (col_sum),
    .col_valid (col_valid),
    .clear     (clear),
    .out_if    (out_if),
    .skew_err  (skew_err),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: sample history per edge plus a queue of accepted rows.
  typedef struct { logic [W-1:0] d; logic [RW-1:0] r; } ent_t;
  ent_t          mq[$];
  logic          hv [64][N];
  logic [DW-1:0] hd [64][N];
  int            edge_cnt = 0;
  int            flush_edge = 0;
  logic [RW-1:0] m_row = '0;
  bit            m_skew = 0, m_ovf = 0;
  int            m_nv, m_e;
  logic [W-1:0]  m_rowdata;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef SA_DRAIN_RELU_EN
    return $signed(x) < 0 ? '0 : x;
`else
    return x;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (clk) edge_cnt++;
      flush_edge = edge_cnt;
      mq.delete();
      m_row = '0; m_skew = 0; m_ovf = 0;
    end else begin
      edge_cnt++;
      m_nv = 0;
      m_rowdata = '0;
      // Column j sampled at edge k-N+j belongs to the row aligned at edge k.
      for (int j = 0; j < N; j++) begin
        m_e = edge_cnt - N + j;
        if (m_e > flush_edge && hv[m_e % 64][j]) begin
          m_nv++;
          m_rowdata[j*DW +: DW] = relu(hd[m_e % 64][j]);
        end
      end
      for (int j = 0; j < N; j++) begin
        hv[edge_cnt % 64][j] = col_valid[j];
        hd[edge_cnt % 64][j] = col_sum[j*DW +: DW];
      end
      if (clear) begin
        flush_edge = edge_cnt;
        mq.delete();
        m_row = '0; m_skew = 0; m_ovf = 0;
      end else begin
        if (mq.size() > 0 && out_if.out_ready) void'(mq.pop_front());
        if (m_nv == N) begin
          if (mq.size() < DEPTH) begin
            mq.push_back('{d: m_rowdata, r: m_row});
            m_row++;
          end else m_ovf = 1;
        end else if (m_nv > 0) m_skew = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", W'(out_if.out_valid), W'(mq.size() != 0));
    check("level", W'(level), W'(mq.size()));
    check("skew_err", W'(skew_err), W'(m_skew));
    check("overflow", W'(overflow), W'(m_ovf));
    if (mq.size() > 0) begin
      check("out_data", out_if.out_data, mq[0].d);
      check("out_row", W'(out_if.out_row), W'(mq[0].r));
    end
  end

  // Stimulus: row r drives column j on cycle r+j.
  logic [DW-1:0] rows  [16][N];
  logic [N-1:0]  masks [16];

  task automatic send(input int nrows);
    int r;
    for (int c = 0; c < nrows + N - 1; c++) begin
      @(negedge clk);
      col_valid = '0;
      col_sum   = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < N; j++) begin
        r = c - j;
        if (r >= 0 && r < nrows && masks[r][j]) begin
          col_valid[j] = 1'b1;
          col_sum[j*DW +: DW] = rows[r][j];
        end
      end
    end
    @(negedge clk);
    col_valid = '0;
    col_sum   = '0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_if.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_if.out_valid) check({name, "_timeout"}, W'(0), W'(1));
  endtask

  task automatic fill(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      masks[r] = '1;
      for (int j = 0; j < N; j++) rows[r][j] = DW'(r * 1000 + j * 7) ^ (j[0] ? 32'h8000_0000 : 32'h0);
    end
  endtask

  initial begin
    col_valid = '0;
    col_sum   = '0;
    clear     = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", W'(out_if.out_valid), W'(0));
    check("rst_level", W'(level), W'(0));
    check("rst_out_data", out_if.out_data, W'(0));
    rst_n = 1'b1;

`ifndef SA_DRAIN_RELU_EN
    rows[0][0] = 32'd10; rows[0][1] = -32'sd20; rows[0][2] = 32'd30; rows[0][3] = -32'sd40;
    masks[0] = '1;
    send(1);
    check("single_not_yet", W'(out_if.out_valid), W'(0));
    @(negedge clk);
    check("single_valid", W'(out_if.out_valid), W'(1));
    check("single_data", out_if.out_data, {32'hFFFF_FFD8, 32'd30, 32'hFFFF_FFEC, 32'd10});
    check("single_row", W'(out_if.out_row), W'(0));
`else
    rows[0][0] = -32'sd5; rows[0][1] = 32'd7; rows[0][2] = 32'h8000_0000; rows[0][3] = 32'd0;
    masks[0] = '1;
    send(1);
    @(negedge clk);
    check("relu_valid", W'(out_if.out_valid), W'(1));
    check("relu_data", out_if.out_data, {32'd0, 32'd0, 32'd7, 32'd0});
`endif

    // Back-to-back with a ready consumer.
    do_clear();
    fill(8);
    send(8);
    repeat (4) @(negedge clk);
    check("b2b_drained", W'(level), W'(0));
    check("b2b_skew", W'(skew_err), W'(0));
    check("b2b_ovf", W'(overflow), W'(0));

    // Backpressure: 6 rows into a 4-deep FIFO.
    do_clear();
    out_if.out_ready = 1'b0;
    fill(6);
    send(6);
    repeat (2) @(negedge clk);
    check("bp_level", W'(level), W'(4));
    check("bp_ovf", W'(overflow), W'(1));
    out_if.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_empty", W'(level), W'(0));
    fill(1);
    send(1);
    wait_valid("bp_next");
    check("bp_next_row", W'(out_if.out_row), W'(4));

    // Skew fault on the middle row.
    do_clear();
    fill(3);
    masks[1] = 4'b1011;
    send(3);
    repeat (3) @(negedge clk);
    check("skew_set", W'(skew_err), W'(1));
    do_clear();
    check("skew_cleared", W'(skew_err), W'(0));

    // Asynchronous reset with three rows parked.
    out_if.out_ready = 1'b0;
    fill(4);
    masks[3] = 4'b0111;
    send(4);
    repeat (2) @(negedge clk);
    check("pre_rst_level", W'(level), W'(3));
    check("pre_rst_valid", W'(out_if.out_valid), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", W'(out_if.out_valid), W'(0));
    check("rst_mid_level", W'(level), W'(0));
    check("rst_mid_skew", W'(skew_err), W'(0));
    check("rst_mid_ovf", W'(overflow), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_if.out_ready = 1'b1;
    fill(1);
    send(1);
    wait_valid("post_rst");
    check("post_rst_row", W'(out_if.out_row), W'(0));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
